// File: rtl/ram_loader_if.sv
// Byte-stream input and single-port RAM bus of ram_loader, grouped so the loader
// takes one bundle; "slave" is the loader side, "master" is the environment side.
interface ram_loader_if #(
  parameter int unsigned ADDR_WIDTH = 22
);
  // Stream handshake: a byte moves on a rising clock when s_valid_i and s_ready_o
  // are both high; the source holds data/last stable while valid waits on ready.
  logic                  s_valid_i;
  logic [7:0]            s_data_i;
  logic                  s_last_i;
  logic                  s_ready_o;
  logic                  en_o;
  logic [ADDR_WIDTH-1:0] addr_o;
  logic [31:0]           wdata_o;
  logic                  we_o;
  logic [3:0]            be_o;
  logic [31:0]           rdata_i;

  modport slave (
    input  s_valid_i, s_data_i, s_last_i, rdata_i,
    output s_ready_o, en_o, addr_o, wdata_o, we_o, be_o
  );

  modport master (
    output s_valid_i, s_data_i, s_last_i, rdata_i,
    input  s_ready_o, en_o, addr_o, wdata_o, we_o, be_o
  );
endinterface

// File: rtl/ram_loader.sv
// Packs a little-endian byte stream into 32-bit RAM writes at consecutive word addresses.
// Define RAM_LOADER_READBACK_EN to read back and compare every written word.
module ram_loader #(
  parameter int unsigned           ADDR_WIDTH = 22,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] start_addr_i,
  input  logic                  use_base_i,
  ram_loader_if.slave           bus,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic [ADDR_WIDTH-1:0] words_o,
  output logic [2:0]            state_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_COLLECT, S_WRITE, S_VRD, S_VCMP, S_DONE
  } state_t;

  state_t                r_state;
  logic                  r_ready;
  logic                  r_en;
  logic                  r_we;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_last;
  logic [1:0]            r_idx;
  logic [3:0]            r_be;
  logic [31:0]           r_wdata;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH-1:0] r_words;
  logic                  w_advance;

`ifdef RAM_LOADER_READBACK_EN
  logic        r_err;
  logic [31:0] w_mask;
  logic        w_mismatch;

  assign w_mask     = {{8{r_be[3]}}, {8{r_be[2]}}, {8{r_be[1]}}, {8{r_be[0]}}};
  assign w_mismatch = |((bus.rdata_i ^ r_wdata) & w_mask);
  assign w_advance  = (r_state == S_VCMP);
  assign err_o      = r_err;
`else
  assign w_advance  = (r_state == S_WRITE);
  assign err_o      = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
      r_ready <= 1'b0;
      r_en    <= 1'b0;
      r_we    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_last  <= 1'b0;
      r_idx   <= 2'd0;
      r_be    <= 4'd0;
      r_wdata <= 32'd0;
      r_addr  <= '0;
      r_words <= '0;
`ifdef RAM_LOADER_READBACK_EN
      r_err   <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_state <= S_COLLECT;
            r_ready <= 1'b1;
            r_busy  <= 1'b1;
            r_addr  <= (use_base_i ? BASE_ADDR : start_addr_i) & ~ADDR_WIDTH'(3);
            r_words <= '0;
            r_idx   <= 2'd0;
            r_be    <= 4'd0;
            r_wdata <= 32'd0;
            r_last  <= 1'b0;
`ifdef RAM_LOADER_READBACK_EN
            r_err   <= 1'b0;
`endif
          end
        end
        S_COLLECT: begin
          // s_ready_o is high throughout COLLECT, so valid alone marks a transfer.
          if (bus.s_valid_i) begin
            r_wdata[{r_idx, 3'b000} +: 8] <= bus.s_data_i;
            r_be[r_idx]                   <= 1'b1;
            r_idx                         <= r_idx + 2'd1;
            if (r_idx == 2'd3 || bus.s_last_i) begin
              r_state <= S_WRITE;
              r_ready <= 1'b0;
              r_en    <= 1'b1;
              r_we    <= 1'b1;
              r_last  <= bus.s_last_i;
            end
          end
        end
        S_WRITE: begin
`ifdef RAM_LOADER_READBACK_EN
          r_state <= S_VRD;
          r_we    <= 1'b0;
`endif
        end
        S_VRD: begin
`ifdef RAM_LOADER_READBACK_EN
          r_state <= S_VCMP;
          r_en    <= 1'b0;
`endif
        end
        S_VCMP: begin
`ifdef RAM_LOADER_READBACK_EN
          if (w_mismatch) r_err <= 1'b1;
`endif
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase

      // Word retirement: shared by the plain write path and the readback path.
      if (w_advance) begin
        r_words <= r_words + ADDR_WIDTH'(1);
        r_addr  <= r_addr + ADDR_WIDTH'(4);
        r_be    <= 4'd0;
        r_wdata <= 32'd0;
        r_idx   <= 2'd0;
        r_en    <= 1'b0;
        r_we    <= 1'b0;
        if (r_last) begin
          r_state <= S_DONE;
          r_done  <= 1'b1;
        end else begin
          r_state <= S_COLLECT;
          r_ready <= 1'b1;
        end
      end
    end
  end

  assign bus.s_ready_o = r_ready;
  assign bus.en_o      = r_en;
  assign bus.we_o      = r_we;
  assign bus.addr_o    = r_addr;
  assign bus.wdata_o   = r_wdata;
  assign bus.be_o      = r_be;
  assign busy_o        = r_busy;
  assign done_o        = r_done;
  assign words_o       = r_words;
  assign state_o       = r_state;

endmodule

// File: tb/tb_ram_loader.sv
// Directed bench for ram_loader: word-packing model, RAM model and per-cycle compare.
module tb_ram_loader;
  localparam int AW = 22;
  localparam logic [AW-1:0] BASE = 22'h000040;
  localparam int W = AW + 36;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          use_base = 1'b0;
  logic [AW-1:0] start_addr = '0;
  logic          busy, done, err;
  logic [AW-1:0] words;
  logic [2:0]    state;

  ram_loader_if #(.ADDR_WIDTH(AW)) bus ();

  ram_loader #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .start_addr_i(start_addr),
    .use_base_i(use_base), .bus(bus), .busy_o(busy), .done_o(done),
    .err_o(err), .words_o(words), .state_o(state)
  );

  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [W-1:0]  exp_q[$];
  logic [W-1:0]  got_q[$];
  logic [7:0]    tx_q[$];
  int            exp_words = 0;
  bit            exp_err = 1'b0;
  int            exp_reads = 0;
  int            checks = 0;
  int            errors = 0;
  int            n_reads = 0;
  int            n_done = 0;
  logic [AW-1:0] last_waddr = '0;
  bit            corrupt = 1'b0;
  bit            abort = 1'b0;
  logic [31:0]   mem [int];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- RAM model (1-cycle read latency) ----------------
  always @(posedge clk) begin : ram_model
    int a;
    logic [31:0] v;
    a = int'(bus.addr_o);
    if (bus.en_o && bus.we_o) begin
      v = mem.exists(a) ? mem[a] : 32'd0;
      for (int k = 0; k < 4; k++)
        if (bus.be_o[k]) v[8*k +: 8] = bus.wdata_o[8*k +: 8];
      mem[a] = v;
    end
    if (bus.en_o && !bus.we_o)
      bus.rdata_i <= corrupt ? 32'hDEADBEEF : (mem.exists(a) ? mem[a] : 32'd0);
  end

  // ---------------- behavioural model: bytes -> expected word writes ----------------
  task automatic expect_load(input logic [AW-1:0] a0, input bit ub, input int nb);
    logic [AW-1:0] a;
    int n;
    a = ub ? BASE : a0;
    a[1:0] = 2'b00;
    n = 0;
    for (int i = 0; i < nb; i += 4) begin
      logic [31:0] d;
      logic [3:0]  be;
      d = '0;
      be = '0;
      for (int k = 0; k < 4 && i + k < nb; k++) begin
        d[8*k +: 8] = tx_q[i+k];
        be[k] = 1'b1;
      end
      exp_q.push_back({a, d, be});
      a = a + AW'(4);
      n++;
    end
    exp_words = n;
`ifdef RAM_LOADER_READBACK_EN
    exp_reads += n;
`endif
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (!busy) check("idle_quiet", {bus.s_ready_o, bus.en_o, bus.we_o}, 3'b000);
      if (bus.en_o) check("ready_during_ram", bus.s_ready_o, 1'b0);
      if (bus.we_o) check("we_without_en", bus.en_o, 1'b1);
      if (bus.en_o && bus.we_o) begin
        last_waddr = bus.addr_o;
        got_q.push_back({bus.addr_o, bus.wdata_o, bus.be_o});
        check("write_pending", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) check("write", {bus.addr_o, bus.wdata_o, bus.be_o}, exp_q.pop_front());
      end
      if (bus.en_o && !bus.we_o) begin
        n_reads++;
        check("read_addr", bus.addr_o, last_waddr);
      end
      if (done) begin
        n_done++;
        check("done_words", words, exp_words);
        check("done_err", err, exp_err);
        check("done_all_written", exp_q.size(), 0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_load(input logic [AW-1:0] a, input bit ub);
    start_addr = a;
    use_base = ub;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic stream(input bit gappy);
    int i, budget;
    bit tog, fire;
    i = 0; budget = 0; tog = 1'b0;
    while (i < tx_q.size() && budget < 400 && !abort) begin
      bus.s_valid_i = gappy ? tog : 1'b1;
      tog = !tog;
      bus.s_data_i = tx_q[i];
      bus.s_last_i = (i == tx_q.size() - 1);
      @(negedge clk);
      fire = bus.s_valid_i && bus.s_ready_o;
      @(posedge clk); #1;
      if (fire) i++;
      budget++;
    end
    bus.s_valid_i = 1'b0;
    bus.s_last_i = 1'b0;
    bus.s_data_i = 8'd0;
    if (!abort) check("stream_accepted", i, tx_q.size());
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 100);
    check("done_seen", done, 1'b1);
    @(negedge clk);
    check("done_one_cycle", done, 1'b0);
    check("busy_after_done", busy, 1'b0);
    @(posedge clk); #1;
  endtask

  task automatic pin(input string name, input int idx, input logic [W-1:0] lit);
    if (idx < got_q.size()) check(name, got_q[idx], lit);
    else check(name, got_q.size(), idx + 1);
  endtask

  task automatic check_reset_outputs();
    check("rst_ready", bus.s_ready_o, 1'b0);
    check("rst_en", bus.en_o, 1'b0);
    check("rst_we", bus.we_o, 1'b0);
    check("rst_be", bus.be_o, 4'h0);
    check("rst_addr", bus.addr_o, 0);
    check("rst_wdata", bus.wdata_o, 0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_words", words, 0);
  endtask

  task automatic run_load(input logic [AW-1:0] a, input bit ub, input bit gappy);
    expect_load(a, ub, tx_q.size());
    start_load(a, ub);
    stream(gappy);
    wait_done();
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- directed sequence ----------------
  initial begin : main
    int g;
    bus.s_valid_i = 1'b0;
    bus.s_data_i  = 8'd0;
    bus.s_last_i  = 1'b0;
    bus.rdata_i   = 32'd0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Two full words from an explicit start address.
    g = got_q.size();
    tx_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    run_load(22'h000100, 1'b0, 1'b0);
    pin("t1_w0", g, {22'h000100, 32'h44332211, 4'hF});
    pin("t1_w1", g + 1, {22'h000104, 32'h88776655, 4'hF});
    check("t1_words", words, 2);

    // Short final word.
    g = got_q.size();
    tx_q = '{8'hAA, 8'hBB};
    run_load(22'h000200, 1'b0, 1'b0);
    pin("t2_w0", g, {22'h000200, 32'h0000BBAA, 4'b0011});
    check("t2_words", words, 1);

    // Address wrap at the top of the space.
    g = got_q.size();
    tx_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    run_load(22'h3FFFFC, 1'b0, 1'b0);
    pin("t3_w0", g, {22'h3FFFFC, 32'h04030201, 4'hF});
    pin("t3_w1", g + 1, {22'h000000, 32'h08070605, 4'hF});

    // BASE_ADDR selected; start_addr_i must be ignored.
    g = got_q.size();
    tx_q = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
    run_load(22'h000777, 1'b1, 1'b0);
    pin("t4_w0", g, {22'h000040, 32'hA4A3A2A1, 4'hF});
    pin("t4_w1", g + 1, {22'h000044, 32'h000000A5, 4'b0001});

    // Unaligned start address has its low bits dropped.
    g = got_q.size();
    tx_q = '{8'hC1, 8'hC2, 8'hC3};
    run_load(22'h000107, 1'b0, 1'b0);
    pin("t5_w0", g, {22'h000104, 32'h00C3C2C1, 4'b0111});

    // start_i pulsed mid-collect must not reload the address.
    g = got_q.size();
    tx_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    expect_load(22'h000100, 1'b0, 8);
    start_load(22'h000100, 1'b0);
    fork
      stream(1'b0);
      begin
        repeat (2) @(posedge clk);
        #1;
        start = 1'b1;
        start_addr = 22'h000500;
        @(posedge clk); #1;
        start = 1'b0;
      end
    join
    wait_done();
    pin("t6_w0", g, {22'h000100, 32'h44332211, 4'hF});
    pin("t6_w1", g + 1, {22'h000104, 32'h88776655, 4'hF});

    // Gappy valid gives identical writes.
    g = got_q.size();
    run_load(22'h000100, 1'b0, 1'b1);
    pin("t7_w0", g, {22'h000100, 32'h44332211, 4'hF});
    pin("t7_w1", g + 1, {22'h000104, 32'h88776655, 4'hF});

    // Corrupted readback data.
    corrupt = 1'b1;
`ifdef RAM_LOADER_READBACK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    tx_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    run_load(22'h000100, 1'b0, 1'b0);
    check("t8_err_sticky", err, exp_err);
    corrupt = 1'b0;

    // A fresh load clears the error flag.
    exp_err = 1'b0;
    tx_q = '{8'h5A, 8'h6B, 8'h7C, 8'h8D, 8'h9E};
    run_load(22'h000600, 1'b0, 1'b0);
    check("t9_err_cleared", err, 1'b0);

    // Reset asserted during the first WRITE abandons the rest.
    tx_q = '{8'hE1, 8'hE2, 8'hE3, 8'hE4, 8'hE5, 8'hE6, 8'hE7, 8'hE8};
    expect_load(22'h000300, 1'b0, 4);
`ifdef RAM_LOADER_READBACK_EN
    exp_reads--;
`endif
    g = n_done;
    start_load(22'h000300, 1'b0);
    abort = 1'b0;
    fork
      stream(1'b0);
      begin
        int n;
        n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (!(bus.en_o && bus.we_o) && n < 50);
        check("t10_write_seen", bus.en_o && bus.we_o, 1'b1);
        #1;
        rst_n = 1'b0;
        abort = 1'b1;
      end
    join
    @(negedge clk);
    check_reset_outputs();
    @(posedge clk); #1;
    rst_n = 1'b1;
    abort = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("t10_no_more_writes", exp_q.size(), 0);
    check("t10_no_done", n_done, g);

`ifdef RAM_LOADER_READBACK_EN
    check("read_count", n_reads, exp_reads);
`else
    check("read_count", n_reads, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_loader.md
RAM_LOADER -- requirements
Module: ram_loader

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 22, byte-address width of the RAM port.
REQ-002 SHALL have parameter BASE_ADDR, default 0, byte address loaded at start when start_addr_i is not used (use_base_i=1).
REQ-003 SHALL have ports: clk_i  in  1  clock; rst_ni  in  1  synchronous active-low reset, sampled on rising clk_i.
REQ-004 SHALL have ports: start_i  in  1  start load; start_addr_i  in  ADDR_WIDTH  first byte address; use_base_i  in  1  select BASE_ADDR.
REQ-005 SHALL have ports: s_valid_i  in  1; s_data_i  in  8; s_last_i  in  1  final byte; s_ready_o  out  1  (byte stream, valid/ready).
REQ-006 SHALL have ports: en_o  out  1; addr_o  out  ADDR_WIDTH; wdata_o  out  32; we_o  out  1; be_o  out  4; rdata_i  in  32  (RAM port, 1-cycle read latency).
REQ-007 SHALL have ports: busy_o  out  1; done_o  out  1  one-cycle pulse; err_o  out  1  sticky readback error; words_o  out  ADDR_WIDTH  words written.

Function
REQ-008 SHALL implement states IDLE, COLLECT, WRITE, VRD, VCMP, DONE.
REQ-009 IDLE: s_ready_o=0, en_o=0, busy_o=0; start_i=1 -> addr register = use_base_i ? BASE_ADDR : start_addr_i with bits [1:0] forced 0, words_o=0, err_o=0, byte index=0, next COLLECT.
REQ-010 COLLECT: s_ready_o=1; a byte is accepted only when s_valid_i & s_ready_o; byte k (k=0..3) lands in wdata bits [8k+7:8k] (little-endian) and sets be bit k.
REQ-011 Transition COLLECT -> WRITE after accepting byte index 3 or any byte with s_last_i=1; last flag latched.
REQ-012 WRITE: exactly one cycle with en_o=1, we_o=1, addr_o=addr register, wdata_o/be_o as assembled (unreceived bytes 0, be bit 0); s_ready_o=0.
REQ-013 After WRITE (or after VCMP when readback enabled): words_o+1, addr += 4 modulo 2^ADDR_WIDTH (silent wrap), be and byte index cleared; next DONE if last flag set else COLLECT.
REQ-014 DONE: done_o=1 for exactly one cycle, busy_o=0 from following cycle, next IDLE.
REQ-015 busy_o SHALL be 1 in every state except IDLE; start_i while busy_o=1 SHALL be ignored.
REQ-016 en_o and we_o SHALL be 0 in IDLE, COLLECT, DONE; no RAM access outside WRITE/VRD.
REQ-017 Stream bytes presented in IDLE, WRITE, VRD, VCMP, DONE SHALL not be accepted (s_ready_o=0).
REQ-018 s_valid_i gaps in COLLECT SHALL stall without timeout.

Reset
REQ-019 rst_ni=0 at a rising edge SHALL force IDLE, s_ready_o=0, en_o=0, we_o=0, be_o=0, addr_o=0, wdata_o=0, busy_o=0, done_o=0, err_o=0, words_o=0, byte index 0.
REQ-020 Reset mid-operation SHALL abandon the partial word with no further RAM write; reset has priority over start_i.

Configuration
REQ-021 Macro RAM_LOADER_READBACK_EN defined: WRITE -> VRD (en_o=1, we_o=0, same addr_o, 1 cycle) -> VCMP (en_o=0; compare rdata_i with wdata under be mask; mismatch sets err_o until next start/reset) -> REQ-013.
REQ-022 Macro undefined: WRITE proceeds directly per REQ-013, VRD/VCMP unreachable, rdata_i ignored, err_o constant 0.

Verification
REQ-023 start_addr_i=0x100, bytes 11,22,33,44,55,66,77,88 (last on 88) -> writes addr 0x100 data 0x44332211 be 1111, addr 0x104 data 0x88776655 be 1111, words_o=2, done_o pulse.
REQ-024 Bytes AA,BB with last on BB -> single write data 0x0000BBAA be 0011, done_o pulse.
REQ-025 start_addr_i=0x3FFFFC (ADDR_WIDTH 22), 8 bytes -> writes at 0x3FFFFC then 0x000000.
REQ-026 start_i pulsed during COLLECT -> no address reload, sequence unchanged; rst_ni=0 during WRITE -> all outputs reset values next cycle, no further en_o.
REQ-027 With RAM_LOADER_READBACK_EN, model returns 0xDEADBEEF for written 0x44332211 -> err_o=1 sticky through done_o; without macro, same stimulus -> err_o=0, no read cycle.
REQ-028 s_valid_i toggled every other cycle -> identical RAM writes, s_ready_o low outside COLLECT.
